uart_cmd_wrapper: RTL
=====================

# uart_cmd_wrapper

DUT-side endpoint of the Bluetooth/UART command link. It receives 8N1 serial bytes on RX, assembles each pair into a 16-bit command (high byte first), and presents it to the command processor with a ready flag. It also serializes 8-bit response bytes (positive acknowledge, error) back to the remote on TX. It is the responder counterpart of the remote-side command initiator, which sends two bytes and waits for one response byte.

## Interface
- BAUD_DIV, 2604: clocks per bit (50 MHz / 19200 baud).
- GAP_TO, 131072: clocks allowed between end of high byte and start of low byte before the pair is abandoned.
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- RX  in  1  serial input, idle high, asynchronous to clk.
- TX  out  1  serial output, idle high.
- cmd  out  16  last assembled command {high, low}.
- cmd_rdy  out  1  level; a new cmd is valid.
- clr_cmd_rdy  in  1  pulse from consumer; clears cmd_rdy.
- resp  in  8  response byte, sampled when trmt is accepted.
- trmt  in  1  pulse; start transmitting resp.
- tx_done  out  1  level; last response fully sent.

## Operation
- RX path: RX double-flopped, both flops reset to 1. Idle until a synchronized falling edge.
- Baud counter loads BAUD_DIV/2 at start detection, then BAUD_DIV per bit. Ten samples are taken: start, 8 data bits LSB first, stop.
- rx_rdy pulses for one clock at the stop sample when stop = 1. If stop = 0 (framing error), the byte is dropped silently.
- If the start bit samples as 1 mid-bit, treat it as a glitch and return to idle with no byte.
- Assembly FSM states:
  - WAIT_HI: on rx_rdy, store the byte in hi_byte and go to WAIT_LO.
  - WAIT_LO: on rx_rdy, load cmd = {hi_byte, byte}, set cmd_rdy, and go to WAIT_HI.
  - WAIT_LO timeout: the gap counter counts while WAIT_LO and the receiver is idle. On reaching GAP_TO, discard hi_byte and go to WAIT_HI.
- cmd_rdy rules:
  - Cleared by clr_cmd_rdy, or when a new high byte is stored.
  - If set and clear coincide, set wins.
  - cmd holds its value until the next full pair.
- TX path:
  - States IDLE and XMIT. In IDLE, trmt loads a shift register with {1, resp, 0}, clears tx_done and enters XMIT.
  - Each BAUD_DIV clocks, shift right and drive TX = shift[0].
  - After 10 bits, return to IDLE and set tx_done.
  - trmt during XMIT is ignored.
- RX and TX are fully independent (full duplex).
- Reset mid-byte aborts both paths immediately. Reset values: TX = 1, cmd = 0, cmd_rdy = 0, tx_done = 0; FSMs in WAIT_HI / IDLE.

## Timing
- Latency from the falling edge of the low byte's start bit to cmd_rdy high: 2 sync clocks + BAUD_DIV/2 + 9·BAUD_DIV + 1 clock (registered set).
- TX: the start bit appears on TX the clock after trmt is accepted.
- tx_done rises 10·BAUD_DIV clocks after trmt.
- Every bit lasts exactly BAUD_DIV clocks; no fractional correction.
- Back-to-back bytes with zero idle between stop and next start must be received; the receiver re-arms on the stop sample.

## Structure
- Shared package: BAUD_DIV default constant, the rx/tx state enums, and the response codes POS_ACK = 8'hA5 and ERR = 8'hE5.
- One natural sub-module, uart_rx: synchronizer, baud counter, shifter; outputs rx_data[7:0] and rx_rdy.
- TX serializer and assembly FSM live in uart_cmd_wrapper.

## Test plan
- Two bytes 8'h57, 8'hF4 back to back -> cmd = 16'h57F4, cmd_rdy = 1 at the computed latency ±1 clock; clr_cmd_rdy -> cmd_rdy = 0 the next clock.
- trmt with resp = 8'hA5 -> TX bit sequence 0,1,0,1,0,0,1,0,1,1 at BAUD_DIV spacing; tx_done = 1 after 10·BAUD_DIV clocks. A second trmt mid-frame does not alter TX.
- High byte 8'h5B, then a gap of GAP_TO+100 clocks, then 8'h50, 8'h04 -> cmd = 16'h5004. No cmd = 16'h5B50 ever presented.
- Byte with stop bit forced 0, then 8'h53, 8'hF4 -> cmd = 16'h53F4; the corrupted byte is never counted.
- 1/4-bit low glitch on RX -> no rx_rdy. Reset asserted mid-TX -> TX = 1, tx_done = 0 immediately.
- Low byte's rx_rdy coincident with clr_cmd_rdy -> cmd_rdy = 1 with the new cmd.

Source files
------------

// File: rtl/uart_cmd_wrapper_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_wrapper_pkg
// Shared definitions for the UART command link endpoint.
//   BAUD_DIV_DEFAULT : clocks per serial bit (50 MHz / 19200 baud)
//   GAP_TO_DEFAULT   : clocks allowed between the high byte and the low byte
//   POS_ACK / ERR    : response codes sent back to the remote
//   rx_state_t       : receiver states
//   tx_state_t       : transmitter states
//   asm_state_t      : command assembly states
// ---------------------------------------------------------------------------
package uart_cmd_wrapper_pkg;

    localparam int BAUD_DIV_DEFAULT = 2604;
    localparam int GAP_TO_DEFAULT   = 131072;

    localparam logic [7:0] POS_ACK = 8'hA5;
    localparam logic [7:0] ERR     = 8'hE5;

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

endpackage

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver: two-flop synchronizer, mid-bit baud sampling and an
// LSB-first shifter.
//   clk, rst_n : system clock, asynchronous active-low reset
//   rx         : serial input, idle high, asynchronous to clk
//   rx_data    : last received byte, valid while rx_rdy is high
//   rx_rdy     : one-clock pulse at the stop sample of a good frame
//   rx_busy    : high while a frame is being received
// ---------------------------------------------------------------------------
module uart_rx
    import uart_cmd_wrapper_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(BAUD_DIV);
    localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(1);

    rx_state_t        state;
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_prev;
    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shift;

    assign rx_data = shift;
    assign rx_busy = (state == RX_RECV);

    // Synchronize RX, find the falling edge of a start bit, then take ten
    // mid-bit samples. The first countdown is half a bit so every later
    // sample lands in the middle of its bit. Returning to idle on the stop
    // sample lets a start bit that follows immediately be caught.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            state    <= RX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            rx_rdy  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        state    <= RX_RECV;
                        baud_cnt <= HALF_BIT;
                        bit_idx  <= '0;
                    end
                end
                RX_RECV: begin
                    if (baud_cnt == SAMPLE_AT) begin
                        baud_cnt <= FULL_BIT;
                        bit_idx  <= bit_idx + 4'd1;
                        if (bit_idx == 4'd0) begin
                            // A start bit that is high mid-bit was a glitch.
                            if (rx_s2) state <= RX_IDLE;
                        end else if (bit_idx == 4'd9) begin
                            // A low stop bit is a framing error: drop the byte.
                            state  <= RX_IDLE;
                            rx_rdy <= rx_s2;
                        end else begin
                            shift <= {rx_s2, shift[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt - SAMPLE_AT;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_wrapper.sv
// ---------------------------------------------------------------------------
// uart_cmd_wrapper
// Responder endpoint of the UART command link. Pairs of received bytes
// (high first) become 16-bit commands; response bytes are serialized on TX.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   RX          : serial input, idle high
//   TX          : serial output, idle high
//   cmd         : last assembled command {high, low}
//   cmd_rdy     : level, a new cmd is valid
//   clr_cmd_rdy : pulse, clears cmd_rdy
//   resp        : response byte, sampled when trmt is accepted
//   trmt        : pulse, start transmitting resp
//   tx_done     : level, last response fully sent
// ---------------------------------------------------------------------------
module uart_cmd_wrapper
    import uart_cmd_wrapper_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT,
    parameter int GAP_TO   = GAP_TO_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int CNT_W = $clog2(BAUD_DIV + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam int GAP_W = $clog2(GAP_TO + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TO - 1);

    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       rx_busy;

    uart_rx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (RX),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .rx_busy (rx_busy)
    );

    asm_state_t       asm_state;
    logic [7:0]       hi_byte;
    logic [GAP_W-1:0] gap_cnt;

    // Command assembly. The gap counter only runs while waiting for the low
    // byte with the line idle; any reception in progress restarts it. A
    // completed pair sets cmd_rdy after the clear so that a coincident
    // clr_cmd_rdy loses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_state <= WAIT_HI;
            hi_byte   <= '0;
            gap_cnt   <= '0;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
        end else begin
            if (clr_cmd_rdy) cmd_rdy <= 1'b0;
            case (asm_state)
                WAIT_HI: begin
                    gap_cnt <= '0;
                    if (rx_rdy) begin
                        hi_byte   <= rx_data;
                        cmd_rdy   <= 1'b0;
                        asm_state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (rx_rdy) begin
                        cmd       <= {hi_byte, rx_data};
                        cmd_rdy   <= 1'b1;
                        gap_cnt   <= '0;
                        asm_state <= WAIT_HI;
                    end else if (rx_busy) begin
                        gap_cnt <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        gap_cnt   <= '0;
                        asm_state <= WAIT_HI;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: asm_state <= WAIT_HI;
            endcase
        end
    end

    tx_state_t        tx_state;
    logic [9:0]       tx_shift;
    logic [CNT_W-1:0] tx_baud;
    logic [3:0]       tx_bit;

    // TX is taken straight from the shift register LSB, so the idle value
    // of all ones keeps the line high and reset forces it high at once.
    assign TX = tx_shift[0];

    // Response serializer: the frame {stop, data, start} shifts out LSB
    // first, one bit every BAUD_DIV clocks; trmt is ignored while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_shift <= '1;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_done  <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (trmt) begin
                        tx_shift <= {1'b1, resp, 1'b0};
                        tx_baud  <= '0;
                        tx_bit   <= '0;
                        tx_done  <= 1'b0;
                        tx_state <= TX_XMIT;
                    end
                end
                TX_XMIT: begin
                    if (tx_baud == BIT_LAST) begin
                        tx_baud <= '0;
                        if (tx_bit == 4'd9) begin
                            tx_shift <= '1;
                            tx_done  <= 1'b1;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_bit   <= tx_bit + 4'd1;
                            tx_shift <= {1'b1, tx_shift[9:1]};
                        end
                    end else begin
                        tx_baud <= tx_baud + 1'b1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule
